mips_mc_ctrl: RTL

- Multicycle MIPS control FSM. It drives the 3-bit ALU ControlSignal, the datapath mux selects and the memory/register strobes.
- It decodes Opcode/Funct from the instruction register and sequences FETCH → DECODE → execute states.
- Memory accesses use a request/ready handshake.
- It also keeps a retired-instruction counter and sticky error flags.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mips_alu_dec.sv | 23 ++
 rtl/mips_mc_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SW  = 3'b101;
    localparam logic [2:0] ALU_LW  = 3'b110;
    localparam logic [2:0] ALU_BEQ = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_RTYPE_WB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_e;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type Funct to ALU control decode with a legality flag.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_legal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory handshake,
// retire counter and sticky error flags.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic [2:0]       ControlSignal,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic             IllegalOp,
    output logic             BusError
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    state_e           r_state;
    state_e           w_next;
    logic [WCW-1:0]   r_wait;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             r_buserr;
    logic             w_wait_st;
    logic             w_limit;
    logic             w_timeout;
    logic [2:0]       w_fn_ctrl;
    logic             w_fn_legal;

    mips_alu_dec u_alu_dec (
        .i_funct    (Funct),
        .o_alu_ctrl (w_fn_ctrl),
        .o_legal    (w_fn_legal)
    );

    assign w_wait_st = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign w_limit   = (r_wait == WCW'(WAIT_LIMIT));
    assign w_timeout = w_wait_st && w_limit && !MemReady;

    assign InstrCount = r_count;
    assign IllegalOp  = r_illegal;
    assign BusError   = r_buserr;

    always_comb begin
        w_next        = r_state;
        ControlSignal = ALU_ADD;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCSource      = PCS_ALU;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;
        RegWrite      = 1'b0;
        InstrDone     = 1'b0;
        // Outputs stay quiet while reset is held, even though
        // the state register already points at FETCH.
        if (Rst_n) begin
            case (r_state)
                S_FETCH: begin
                    ALUSrcB = SRCB_FOUR;
                    MemRead = !w_limit;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM4;
                    case (Opcode)
                        OP_RTYPE:     w_next = S_EXEC_R;
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_J:         w_next = S_JUMP;
                        default:      w_next = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    ALUSrcA       = 1'b1;
                    ControlSignal = w_fn_ctrl;
                    w_next = w_fn_legal ? S_RTYPE_WB : S_ILLEGAL;
                end
                S_RTYPE_WB: begin
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    if (Opcode == OP_SW) begin
                        ControlSignal = ALU_SW;
                        w_next        = S_MEMWR;
                    end else begin
                        ControlSignal = ALU_LW;
                        w_next        = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = !w_limit;
                    if (MemReady)     w_next = S_MEMWB;
                    else if (w_limit) w_next = S_FETCH;
                end
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    MemToReg  = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = !w_limit;
                    if (MemReady) begin
                        InstrDone = 1'b1;
                        w_next    = S_FETCH;
                    end else if (w_limit) begin
                        w_next = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ControlSignal = ALU_BEQ;
                    PCWriteCond   = 1'b1;
                    PCSource      = PCS_OUT;
                    InstrDone     = 1'b1;
                    w_next        = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite   = 1'b1;
                    PCSource  = PCS_JMP;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_st && !MemReady && !w_limit)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (InstrDone)
                r_count <= r_count + 1'b1;
            if (r_state == S_ILLEGAL)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_buserr <= 1'b1;
        end
    end

endmodule
